// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter: shares one spi_master (AD9517, ADC0, ADC1 on a single
// 3-wire SDIO bus) between N_REQ config requesters. A requester holds req_i
// for its whole config sequence and, once granted, owns the bus until it
// drops req_i and the master has gone idle. Grants rotate round-robin.
// Optional feature: define SPI_ARB_WDOG_EN to enable the idle-hold watchdog
// that reclaims the bus from an owner that sits idle for WDOG_CYCLES cycles.
module spi_bus_arbiter #(
    parameter int N_REQ           = 3,
    parameter int MOSI_DATA_WIDTH = 24,
    parameter int MISO_DATA_WIDTH = 8,
    parameter int WDOG_CYCLES     = 4096
) (
    input  logic                               clk_20m,
    input  logic                               rstn,
    input  logic [N_REQ-1:0]                   req_i,
    input  logic [N_REQ-1:0]                   wr_cmd_i,
    input  logic [N_REQ-1:0]                   rd_cmd_i,
    input  logic [N_REQ*MOSI_DATA_WIDTH-1:0]   wr_data_i,
    output logic [N_REQ-1:0]                   gnt_o,
    output logic [N_REQ-1:0]                   busy_o,
    output logic [MISO_DATA_WIDTH:0]           rd_data_o,
    output logic [N_REQ-1:0]                   cs_n_o,
    output logic                               spi_wr_cmd_o,
    output logic                               spi_rd_cmd_o,
    output logic [MOSI_DATA_WIDTH-1:0]         spi_wr_data_o,
    input  logic                               spi_busy_i,
    input  logic                               spi_ncs_i,
    input  logic [MISO_DATA_WIDTH:0]           spi_rd_data_i,
    output logic                               cmd_drop_o,
    output logic                               wdog_err_o
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARB   = 2'd1;
    localparam logic [1:0] ST_OWNED = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    logic [1:0]                 state;
    logic [IDX_W-1:0]           rr_ptr;
    logic [IDX_W-1:0]           win_idx;
    logic                       win_vld;
    logic [IDX_W-1:0]           next_ptr;
    logic [N_REQ-1:0]           arb_req;
    logic [1:0]                 guard_cnt;
    logic                       guard_act;
    logic                       own_wr;
    logic                       own_rd;
    logic                       nonown_strb;
    logic                       fwd_ok;
    logic                       fwd_go;
    logic                       drop_p0;
    logic                       own_req;
    logic                       wdog_trip;
    logic [MOSI_DATA_WIDTH-1:0] own_data;

    // Read data from the master is fanned out unchanged to every requester.
    assign rd_data_o = spi_rd_data_i;

    // The guard covers the cycles between issuing a strobe and the master
    // raising spi_busy_i, so a second strobe cannot slip into that gap.
    assign guard_act = (guard_cnt != 2'd0);

    // Non-owners always see busy; the owner sees the master plus the guard.
    assign busy_o = ~gnt_o | {N_REQ{spi_busy_i | guard_act}};

    // Owner strobes are isolated with the one-hot grant; anything else is foreign.
    assign own_wr      = |(wr_cmd_i & gnt_o);
    assign own_rd      = |(rd_cmd_i & gnt_o);
    assign nonown_strb = |((wr_cmd_i | rd_cmd_i) & ~gnt_o);
    assign own_req     = |(req_i & gnt_o);

    assign fwd_ok = (state == ST_OWNED) && !guard_act && !spi_busy_i;
    assign fwd_go = fwd_ok && (own_wr || own_rd);

    // A read arriving together with a write is discarded; the write wins.
    assign drop_p0 = nonown_strb
                   | ((own_wr | own_rd) & ~fwd_ok)
                   | (fwd_ok & own_wr & own_rd);

    // Select the owner's write word from the packed data bus.
    always_comb begin
        own_data = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (gnt_o[k]) begin
                own_data = wr_data_i[k*MOSI_DATA_WIDTH +: MOSI_DATA_WIDTH];
            end
        end
    end

    // Round-robin search: first requester at or after rr_ptr, wrapping.
    always_comb begin
        int               j;
        logic [IDX_W-1:0] cand;
        win_vld = 1'b0;
        win_idx = '0;
        j       = 0;
        cand    = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            j = int'(rr_ptr) + i;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            cand = IDX_W'(j);
            if (arb_req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    assign next_ptr = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;

    // Only the owner's device sees the master chip select while a session is open.
    always_comb begin
        cs_n_o = '1;
        if ((state == ST_OWNED) || (state == ST_DRAIN)) begin
            cs_n_o = ~(gnt_o & {N_REQ{~spi_ncs_i}});
        end
    end

    // Session FSM: arbitrate, hold the grant, drain the master, release.
    always_ff @(posedge clk_20m) begin
        if (!rstn) begin
            state  <= ST_IDLE;
            rr_ptr <= '0;
            gnt_o  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|req_i) begin
                        state <= ST_ARB;
                    end
                end
                ST_ARB: begin
                    if (win_vld) begin
                        gnt_o  <= N_REQ'(1) << win_idx;
                        rr_ptr <= next_ptr;
                        state  <= ST_OWNED;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_OWNED: begin
                    if (wdog_trip || !own_req) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!spi_busy_i && !guard_act) begin
                        gnt_o <= '0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Command forwarding into the master, drop flag and the busy-rise guard.
    always_ff @(posedge clk_20m) begin
        if (!rstn) begin
            spi_wr_cmd_o  <= 1'b0;
            spi_rd_cmd_o  <= 1'b0;
            spi_wr_data_o <= '0;
            cmd_drop_o    <= 1'b0;
            guard_cnt     <= 2'd0;
        end else begin
            spi_wr_cmd_o <= fwd_go & own_wr;
            spi_rd_cmd_o <= fwd_go & own_rd & ~own_wr;
            cmd_drop_o   <= drop_p0;
            if (fwd_go) begin
                spi_wr_data_o <= own_data;
            end
            if (fwd_go) begin
                guard_cnt <= 2'd2;
            end else if (guard_act) begin
                guard_cnt <= guard_cnt - 2'd1;
            end
        end
    end

`ifdef SPI_ARB_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

    logic [WDOG_W-1:0] wdog_cnt;
    logic [N_REQ-1:0]  wdog_mask;
    logic              wdog_err_q;

    // The watchdog fires on the last idle cycle an owner is allowed to hold.
    assign wdog_trip  = (state == ST_OWNED) && !spi_busy_i && !fwd_go
                      && (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));
    assign arb_req    = req_i & ~wdog_mask;
    assign wdog_err_o = wdog_err_q;

    // Idle counter, sticky error and mask of the evicted owner until it lets go.
    always_ff @(posedge clk_20m) begin
        if (!rstn) begin
            wdog_cnt   <= '0;
            wdog_mask  <= '0;
            wdog_err_q <= 1'b0;
        end else begin
            if (fwd_go || (state == ST_ARB)) begin
                wdog_cnt <= '0;
            end else if ((state == ST_OWNED) && !spi_busy_i && !wdog_trip) begin
                wdog_cnt <= wdog_cnt + 1'b1;
            end
            if (wdog_trip) begin
                wdog_err_q <= 1'b1;
            end
            wdog_mask <= (wdog_mask | (wdog_trip ? gnt_o : '0)) & req_i;
        end
    end
`else
    logic unused_wdog;

    assign wdog_trip   = 1'b0;
    assign arb_req     = req_i;
    assign wdog_err_o  = 1'b0;
    assign unused_wdog = (WDOG_CYCLES != 0);
`endif

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Bench for spi_bus_arbiter: small spi_master behavioural model, a scoreboard
// of commands expected at the master port, and directed session sequences.
module tb_spi_bus_arbiter;

    localparam int N   = 3;
    localparam int MW  = 24;
    localparam int RW  = 8;

    logic              clk_20m = 1'b0;
    logic              rstn;
    logic [N-1:0]      req_i;
    logic [N-1:0]      wr_cmd_i;
    logic [N-1:0]      rd_cmd_i;
    logic [N*MW-1:0]   wr_data_i;
    logic [N-1:0]      gnt_o;
    logic [N-1:0]      busy_o;
    logic [RW:0]       rd_data_o;
    logic [N-1:0]      cs_n_o;
    logic              spi_wr_cmd_o;
    logic              spi_rd_cmd_o;
    logic [MW-1:0]     spi_wr_data_o;
    logic              spi_busy_i;
    logic              spi_ncs_i;
    logic [RW:0]       spi_rd_data_i;
    logic              cmd_drop_o;
    logic              wdog_err_o;

    typedef struct packed {
        logic          wr;
        logic [MW-1:0] data;
    } exp_t;

    exp_t  sb_q[$];
    exp_t  sb_e;
    int    n_chk     = 0;
    int    n_fail    = 0;
    int    drop_exp  = 0;
    int    drop_seen = 0;
    logic [3:0] m_cnt;

    always #25 clk_20m = ~clk_20m;

    spi_bus_arbiter #(
        .N_REQ(N),
        .MOSI_DATA_WIDTH(MW),
        .MISO_DATA_WIDTH(RW),
        .WDOG_CYCLES(16)
    ) dut (
        .clk_20m(clk_20m),
        .rstn(rstn),
        .req_i(req_i),
        .wr_cmd_i(wr_cmd_i),
        .rd_cmd_i(rd_cmd_i),
        .wr_data_i(wr_data_i),
        .gnt_o(gnt_o),
        .busy_o(busy_o),
        .rd_data_o(rd_data_o),
        .cs_n_o(cs_n_o),
        .spi_wr_cmd_o(spi_wr_cmd_o),
        .spi_rd_cmd_o(spi_rd_cmd_o),
        .spi_wr_data_o(spi_wr_data_o),
        .spi_busy_i(spi_busy_i),
        .spi_ncs_i(spi_ncs_i),
        .spi_rd_data_i(spi_rd_data_i),
        .cmd_drop_o(cmd_drop_o),
        .wdog_err_o(wdog_err_o)
    );

    // Master model: busy and ncs low for 8 cycles, starting one cycle after a strobe.
    always @(posedge clk_20m) begin
        if (!rstn) begin
            m_cnt <= 4'd0;
        end else if (spi_wr_cmd_o || spi_rd_cmd_o) begin
            m_cnt <= 4'd8;
        end else if (m_cnt != 4'd0) begin
            m_cnt <= m_cnt - 4'd1;
        end
    end
    assign spi_busy_i = (m_cnt != 4'd0);
    assign spi_ncs_i  = (m_cnt == 4'd0);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer and drop counter, sampled on the falling edge.
    always @(negedge clk_20m) begin
        if (rstn === 1'b1) begin
            if (cmd_drop_o) drop_seen <= drop_seen + 1;
            if (spi_wr_cmd_o || spi_rd_cmd_o) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_cmd", 64'(1), 64'(0));
                end else begin
                    sb_e = sb_q.pop_front();
                    chk("sb_wr", 64'(spi_wr_cmd_o), 64'(sb_e.wr));
                    chk("sb_rd", 64'(spi_rd_cmd_o), 64'(!sb_e.wr));
                    if (sb_e.wr) chk("sb_data", 64'(spi_wr_data_o), 64'(sb_e.data));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_20m);
        #1;
    endtask

    task automatic set_data(input int k, input logic [MW-1:0] v);
        wr_data_i[k*MW +: MW] = v;
    endtask

    task automatic push(input logic wr, input logic [MW-1:0] d);
        exp_t e;
        e.wr   = wr;
        e.data = d;
        sb_q.push_back(e);
    endtask

    task automatic clear_strb();
        wr_cmd_i = '0;
        rd_cmd_i = '0;
    endtask

    task automatic wait_free();
        step();
        step();
        for (int i = 0; i < 40 && spi_busy_i; i++) step();
        chk("wait_free", 64'(spi_busy_i), 64'(0));
    endtask

    task automatic wait_regrant(input string tag, input logic [N-1:0] exp);
        for (int i = 0; i < 30 && gnt_o != '0; i++) step();
        for (int i = 0; i < 30 && gnt_o == '0; i++) step();
        chk(tag, 64'(gnt_o), 64'(exp));
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        step();
        step();
        rstn = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rstn          = 1'b0;
        req_i         = '0;
        wr_cmd_i      = '0;
        rd_cmd_i      = '0;
        wr_data_i     = '0;
        spi_rd_data_i = 9'h1A5;
        step();
        step();
        step();

        // Reset values
        chk("rst_gnt", 64'(gnt_o), 64'(0));
        chk("rst_busy", 64'(busy_o), 64'(3'b111));
        chk("rst_cs", 64'(cs_n_o), 64'(3'b111));
        chk("rst_wr", 64'(spi_wr_cmd_o), 64'(0));
        chk("rst_rd", 64'(spi_rd_cmd_o), 64'(0));
        chk("rst_data", 64'(spi_wr_data_o), 64'(0));
        chk("rst_drop", 64'(cmd_drop_o), 64'(0));
        chk("rst_wdog", 64'(wdog_err_o), 64'(0));
        chk("rst_rdata", 64'(rd_data_o), 64'(9'h1A5));

        // Single requester 0, write 0x000010, with a foreign read from 2
        rstn  = 1'b1;
        req_i = 3'b001;
        step();
        chk("t1_gnt_arb", 64'(gnt_o), 64'(0));
        step();
        chk("t1_gnt", 64'(gnt_o), 64'(3'b001));
        chk("t1_busy", 64'(busy_o), 64'(3'b110));
        chk("t1_cs_idle", 64'(cs_n_o), 64'(3'b111));
        wr_cmd_i = 3'b001;
        rd_cmd_i = 3'b100;
        set_data(0, 24'h000010);
        push(1'b1, 24'h000010);
        drop_exp++;
        step();
        chk("t1_wr_cmd", 64'(spi_wr_cmd_o), 64'(1));
        chk("t1_rd_cmd", 64'(spi_rd_cmd_o), 64'(0));
        chk("t1_wr_data", 64'(spi_wr_data_o), 64'(24'h000010));
        chk("t1_drop", 64'(cmd_drop_o), 64'(1));
        chk("t1_busy_guard", 64'(busy_o), 64'(3'b111));
        clear_strb();
        step();
        chk("t1_wr_cmd_end", 64'(spi_wr_cmd_o), 64'(0));
        chk("t1_drop_end", 64'(cmd_drop_o), 64'(0));
        chk("t1_cs_active", 64'(cs_n_o), 64'(3'b110));
        for (int i = 0; i < 40 && spi_busy_i; i++) step();
        chk("t1_busy_free", 64'(busy_o), 64'(3'b110));
        chk("t1_cs_done", 64'(cs_n_o), 64'(3'b111));

        // Owner write and read in the same cycle: write forwarded, read dropped
        wr_cmd_i = 3'b001;
        rd_cmd_i = 3'b001;
        set_data(0, 24'h0000AB);
        push(1'b1, 24'h0000AB);
        drop_exp++;
        step();
        chk("wr_rd_wr", 64'(spi_wr_cmd_o), 64'(1));
        chk("wr_rd_rd", 64'(spi_rd_cmd_o), 64'(0));
        chk("wr_rd_drop", 64'(cmd_drop_o), 64'(1));
        clear_strb();
        wait_free();

        // Owner read, read data passes straight through
        rd_cmd_i = 3'b001;
        push(1'b0, 24'h0);
        step();
        chk("rd_cmd", 64'(spi_rd_cmd_o), 64'(1));
        clear_strb();
        spi_rd_data_i = 9'h0C3;
        #1;
        chk("rd_data", 64'(rd_data_o), 64'(9'h0C3));
        wait_free();

        // Owner drops req mid-transfer: grant held until master idle
        wr_cmd_i = 3'b001;
        set_data(0, 24'h123456);
        push(1'b1, 24'h123456);
        step();
        clear_strb();
        step();
        req_i = 3'b000;
        step();
        chk("t5_gnt_drain", 64'(gnt_o), 64'(3'b001));
        for (int i = 0; i < 40 && spi_busy_i; i++) step();
        chk("t5_gnt_last", 64'(gnt_o), 64'(3'b001));
        step();
        chk("t5_gnt_rel", 64'(gnt_o), 64'(3'b000));
        chk("t5_busy_rel", 64'(busy_o), 64'(3'b111));
        chk("t5_cs_rel", 64'(cs_n_o), 64'(3'b111));

        // Simultaneous requests from pointer 0: 001, 010, 100, then wrap to 0
        do_reset();
        req_i = 3'b111;
        step();
        step();
        chk("t2_gnt0", 64'(gnt_o), 64'(3'b001));
        req_i = 3'b110;
        wait_regrant("t2_gnt1", 3'b010);

        // Owner 1 strobes while master busy: dropped
        wr_cmd_i = 3'b010;
        set_data(1, 24'h00AA55);
        push(1'b1, 24'h00AA55);
        step();
        clear_strb();
        step();
        chk("t3_master_busy", 64'(spi_busy_i), 64'(1));
        wr_cmd_i = 3'b010;
        set_data(1, 24'h111111);
        drop_exp++;
        step();
        chk("t3_no_fwd", 64'(spi_wr_cmd_o), 64'(0));
        chk("t3_drop", 64'(cmd_drop_o), 64'(1));
        clear_strb();
        step();
        chk("t3_drop_end", 64'(cmd_drop_o), 64'(0));
        for (int i = 0; i < 40 && spi_busy_i; i++) step();
        chk("t3_busy_free", 64'(busy_o), 64'(3'b101));

        req_i = 3'b100;
        wait_regrant("t2_gnt2", 3'b100);

        // Owner 2 strobes inside the guard window: dropped
        rd_cmd_i = 3'b100;
        push(1'b0, 24'h0);
        step();
        chk("guard_rd_fwd", 64'(spi_rd_cmd_o), 64'(1));
        drop_exp++;
        step();
        chk("guard_rd_blk", 64'(spi_rd_cmd_o), 64'(0));
        chk("guard_drop", 64'(cmd_drop_o), 64'(1));
        clear_strb();
        wait_free();

        req_i = 3'b011;
        wait_regrant("t2_wrap", 3'b001);
        req_i = 3'b000;
        for (int i = 0; i < 30 && gnt_o != '0; i++) step();
        chk("t2_idle", 64'(gnt_o), 64'(0));

        // Reset in the middle of a transfer
        req_i = 3'b001;
        for (int i = 0; i < 30 && gnt_o == '0; i++) step();
        chk("mr_gnt", 64'(gnt_o), 64'(3'b001));
        wr_cmd_i = 3'b001;
        set_data(0, 24'h777777);
        push(1'b1, 24'h777777);
        step();
        clear_strb();
        step();
        chk("mr_busy", 64'(spi_busy_i), 64'(1));
        rstn  = 1'b0;
        req_i = 3'b000;
        step();
        chk("mr_gnt_rst", 64'(gnt_o), 64'(0));
        chk("mr_busy_rst", 64'(busy_o), 64'(3'b111));
        chk("mr_cs_rst", 64'(cs_n_o), 64'(3'b111));
        chk("mr_wr_rst", 64'(spi_wr_cmd_o), 64'(0));
        chk("mr_data_rst", 64'(spi_wr_data_o), 64'(0));
        chk("mr_drop_rst", 64'(cmd_drop_o), 64'(0));
        rstn = 1'b1;
        step();

`ifdef SPI_ARB_WDOG_EN
        // Idle owner evicted by the watchdog, pending requester 1 granted
        do_reset();
        req_i = 3'b011;
        for (int i = 0; i < 30 && gnt_o == '0; i++) step();
        chk("wd_gnt0", 64'(gnt_o), 64'(3'b001));
        for (int i = 0; i < 40 && !wdog_err_o; i++) step();
        chk("wd_err", 64'(wdog_err_o), 64'(1));
        wait_regrant("wd_gnt1", 3'b010);
        chk("wd_sticky", 64'(wdog_err_o), 64'(1));
        rstn = 1'b0;
        step();
        chk("wd_rst_gnt", 64'(gnt_o), 64'(0));
        chk("wd_rst_err", 64'(wdog_err_o), 64'(0));
        chk("wd_rst_busy", 64'(busy_o), 64'(3'b111));
        rstn  = 1'b1;
        req_i = 3'b000;
        step();
`else
        chk("wdog_tied", 64'(wdog_err_o), 64'(0));
`endif

        step();
        step();
        chk("sb_leftover", 64'(sb_q.size()), 64'(0));
        chk("drop_count", 64'(drop_seen), 64'(drop_exp));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
